// File: rtl/sha_block_sequencer.sv
//------------------------------------------------------------------------------
// sha_block_sequencer
//
// Control sequencer for one double-SHA-256 nonce trial on a shared compression
// datapath and H-register bank:
//   INIT  : H bank reloads the IV
//   R1/U1 : compress chunk 1, then accumulate into H
//   R2/U2 : compress chunk 2 (carries the nonce), then accumulate
//   R3/U3 : compress the second hash, then accumulate
//   CHECK : compare the top digest word against the target
//   DONE  : hold the result until the consumer takes it
// With sweep set, a miss restarts straight into INIT with the next nonce.
//
// Ports
//   clk, rst_n      : rising-edge clock, asynchronous active-low reset
//   start           : trial request, accepted when start && start_ready
//   start_ready     : high only while idle
//   nonce_in        : first nonce, captured on accept
//   sweep           : captured on accept; 1 = continue with nonce+1 on a miss
//   abort           : synchronous return to idle from any busy state
//   target          : unsigned threshold, sampled in CHECK
//   hash_word       : most significant final digest word, sampled in CHECK
//   block_sel       : Block select for the H registers
//   round_idx       : current round 0..ROUNDS-1
//   round_en        : compression datapath advances this cycle
//   h_update        : H bank accumulates this cycle
//   nonce_cur       : nonce of the trial in progress
//   busy            : not idle
//   result_valid    : result available (valid/ready with result_ready)
//   result_ready    : consumer accepts the result
//   result_hit      : hash_word <= target
//   result_nonce    : nonce that produced the result
//
// Every output is a register. The always_comb block only computes the next
// state; the single always_ff then loads the state register together with the
// outputs decoded from that next state, so outputs change exactly at state
// boundaries and never glitch.
//------------------------------------------------------------------------------
module sha_block_sequencer #(
    parameter int ROUNDS  = 64,
    parameter int NONCE_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               start_ready,
    input  logic [NONCE_W-1:0] nonce_in,
    input  logic               sweep,
    input  logic               abort,
    input  logic [31:0]        target,
    input  logic [31:0]        hash_word,
    output logic [1:0]         block_sel,
    output logic [5:0]         round_idx,
    output logic               round_en,
    output logic               h_update,
    output logic [NONCE_W-1:0] nonce_cur,
    output logic               busy,
    output logic               result_valid,
    input  logic               result_ready,
    output logic               result_hit,
    output logic [NONCE_W-1:0] result_nonce
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_R1,
        S_U1,
        S_R2,
        S_U2,
        S_R3,
        S_U3,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    state_t state;
    state_t state_nxt;
    logic   sweep_q;
    logic   last_round;
    logic   sweep_go;
    logic   accept;
    logic   handshake;

    assign last_round = (round_idx == LAST_ROUND);
    assign accept     = (state == S_IDLE) && start;
    assign handshake  = (state == S_DONE) && result_ready && !abort;

    // A sweep only continues on a miss, and stops at the top of the nonce
    // range instead of wrapping back to zero.
    assign sweep_go   = sweep_q && !result_hit && (nonce_cur != '1);

    // Block select seen by the H registers while in state s. It steps only
    // at the U states, so each nonzero Block is presented once per trial.
    function automatic logic [1:0] block_of(input state_t s);
        logic [1:0] b;
        case (s)
            S_U1, S_R2:              b = 2'd1;
            S_U2, S_R3:              b = 2'd2;
            S_U3, S_CHECK, S_DONE:   b = 2'd3;
            default:                 b = 2'd0;
        endcase
        return b;
    endfunction

    function automatic logic is_round(input state_t s);
        return (s == S_R1) || (s == S_R2) || (s == S_R3);
    endfunction

    function automatic logic is_update(input state_t s);
        return (s == S_U1) || (s == S_U2) || (s == S_U3);
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_INIT;
            S_INIT:  state_nxt = S_R1;
            S_R1:    if (last_round) state_nxt = S_U1;
            S_U1:    state_nxt = S_R2;
            S_R2:    if (last_round) state_nxt = S_U2;
            S_U2:    state_nxt = S_R3;
            S_R3:    if (last_round) state_nxt = S_U3;
            S_U3:    state_nxt = S_CHECK;
            S_CHECK: state_nxt = S_DONE;
            S_DONE:  if (result_ready) state_nxt = sweep_go ? S_INIT : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // abort wins over the round counter and over the result handshake
        if (abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            sweep_q      <= 1'b0;
            block_sel    <= 2'd0;
            round_idx    <= 6'd0;
            round_en     <= 1'b0;
            h_update     <= 1'b0;
            busy         <= 1'b0;
            start_ready  <= 1'b1;
            result_valid <= 1'b0;
            result_hit   <= 1'b0;
            result_nonce <= '0;
            nonce_cur    <= '0;
        end else begin
            state        <= state_nxt;
            block_sel    <= block_of(state_nxt);
            round_en     <= is_round(state_nxt);
            h_update     <= is_update(state_nxt);
            busy         <= (state_nxt != S_IDLE);
            start_ready  <= (state_nxt == S_IDLE);
            result_valid <= (state_nxt == S_DONE);

            // Counter runs only while staying inside one round state; any
            // entry, exit or abort brings it back to zero.
            if (is_round(state_nxt) && (state_nxt == state)) begin
                round_idx <= round_idx + 6'd1;
            end else begin
                round_idx <= 6'd0;
            end

            if (accept) begin
                nonce_cur <= nonce_in;
                sweep_q   <= sweep;
            end else if (handshake && sweep_go) begin
                nonce_cur <= nonce_cur + NONCE_W'(1);
            end

            if ((state == S_CHECK) && (state_nxt == S_DONE)) begin
                result_hit   <= (hash_word <= target);
                result_nonce <= nonce_cur;
            end
        end
    end

endmodule

// File: tb/tb_sha_block_sequencer.sv
module tb_sha_block_sequencer;

    localparam int ROUNDS  = 64;
    localparam int NONCE_W = 32;
    localparam int LAT     = 3 * ROUNDS + 5;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               start_ready;
    logic [NONCE_W-1:0] nonce_in;
    logic               sweep;
    logic               abort;
    logic [31:0]        target;
    logic [31:0]        hash_word;
    logic [1:0]         block_sel;
    logic [5:0]         round_idx;
    logic               round_en;
    logic               h_update;
    logic [NONCE_W-1:0] nonce_cur;
    logic               busy;
    logic               result_valid;
    logic               result_ready;
    logic               result_hit;
    logic [NONCE_W-1:0] result_nonce;

    sha_block_sequencer #(.ROUNDS(ROUNDS), .NONCE_W(NONCE_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .start_ready  (start_ready),
        .nonce_in     (nonce_in),
        .sweep        (sweep),
        .abort        (abort),
        .target       (target),
        .hash_word    (hash_word),
        .block_sel    (block_sel),
        .round_idx    (round_idx),
        .round_en     (round_en),
        .h_update     (h_update),
        .nonce_cur    (nonce_cur),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_hit   (result_hit),
        .result_nonce (result_nonce)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic               hit;
        logic [NONCE_W-1:0] nonce;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   t0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns all-X when nothing was expected so the comparison cannot match.
    function automatic exp_t sb_pop();
        exp_t e;
        e = 'x;
        if (sb.size() > 0) e = sb.pop_front();
        return e;
    endfunction

    task automatic do_start(input logic [NONCE_W-1:0] n, input logic sw);
        nonce_in = n;
        sweep    = sw;
        start    = 1'b1;
        tick();
        t0    = cyc;
        start = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output bit ok, output int hupd,
                              output int ren, output int nchg, output logic [7:0] seq);
        logic [1:0] prev;
        ok   = 1'b0;
        hupd = 0;
        ren  = 0;
        nchg = 0;
        prev = block_sel;
        seq  = {6'd0, block_sel};
        for (int i = 0; i < limit && !ok; i++) begin
            tick();
            if (h_update) hupd++;
            if (round_en) ren++;
            if (block_sel != prev) begin
                nchg++;
                seq  = {seq[5:0], block_sel};
                prev = block_sel;
            end
            if (result_valid) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({block_sel, round_idx, round_en, h_update, nonce_cur, busy, result_valid,
             result_hit, result_nonce} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got sel=%0d idx=%0d ren=%b hu=%b nc=%h busy=%b v=%b hit=%b rn=%h, required all 0",
                     block_sel, round_idx, round_en, h_update, nonce_cur, busy, result_valid,
                     result_hit, result_nonce);
        end
        n_cmp++;
        if (start_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_start_ready: got %b required 1", start_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bit ok; int hupd, ren, nchg; logic [7:0] seq; exp_t e;
        hash_word    = 32'h0000_1000;
        target       = 32'h0000_FFFF;
        result_ready = 1'b1;
        sb.push_back('{hit: 1'b1, nonce: 32'h10});
        do_start(32'h10, 1'b0);
        wait_valid(400, ok, hupd, ren, nchg, seq);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL single_timeout: result_valid never rose"); end
        n_cmp++;
        if (cyc - t0 !== LAT) begin
            n_fail++; $display("FAIL single_latency: got %0d required %0d", cyc - t0, LAT);
        end
        n_cmp++;
        if (seq !== 8'h1B || nchg !== 3) begin
            n_fail++; $display("FAIL single_block_seq: got %h/%0d changes required 1b/3", seq, nchg);
        end
        n_cmp++;
        if (hupd !== 3) begin n_fail++; $display("FAIL single_h_update: got %0d required 3", hupd); end
        n_cmp++;
        if (ren !== 3 * ROUNDS) begin
            n_fail++; $display("FAIL single_round_en: got %0d required %0d", ren, 3 * ROUNDS);
        end
        n_cmp++;
        if (block_sel !== 2'd3) begin n_fail++; $display("FAIL single_done_sel: got %0d required 3", block_sel); end
        e = sb_pop();
        n_cmp++;
        if ({result_hit, result_nonce} !== {e.hit, e.nonce}) begin
            n_fail++; $display("FAIL single_result: got hit=%b nonce=%h required hit=%b nonce=%h",
                               result_hit, result_nonce, e.hit, e.nonce);
        end
        tick();
        n_cmp++;
        if (start_ready !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_idle_after: got rdy=%b busy=%b v=%b required 1/0/0",
                               start_ready, busy, result_valid);
        end
    endtask

    task automatic test_backpressure();
        bit ok; int hupd, ren, nchg; logic [7:0] seq; exp_t e; bit held;
        hash_word    = 32'h0000_5000;
        target       = 32'h0000_5000;   // equal: boundary of <=
        result_ready = 1'b0;
        sb.push_back('{hit: 1'b1, nonce: 32'hA5A5_0001});
        do_start(32'hA5A5_0001, 1'b0);
        wait_valid(400, ok, hupd, ren, nchg, seq);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL bp_timeout: result_valid never rose"); end
        e = sb_pop();
        n_cmp++;
        if ({result_hit, result_nonce} !== {e.hit, e.nonce}) begin
            n_fail++; $display("FAIL bp_result: got hit=%b nonce=%h required hit=%b nonce=%h",
                               result_hit, result_nonce, e.hit, e.nonce);
        end
        held      = 1'b1;
        start     = 1'b1;
        nonce_in  = 32'h0BAD_0BAD;
        hash_word = 32'hFFFF_FFFF;     // changes in DONE must not disturb the result
        for (int i = 0; i < 10; i++) begin
            tick();
            if (result_valid !== 1'b1 || result_hit !== e.hit || result_nonce !== e.nonce ||
                start_ready !== 1'b0 || nonce_cur !== e.nonce) held = 1'b0;
        end
        n_cmp++;
        if (!held) begin
            n_fail++; $display("FAIL bp_hold: got v=%b hit=%b nonce=%h rdy=%b required 1/%b/%h/0",
                               result_valid, result_hit, result_nonce, start_ready, e.hit, e.nonce);
        end
        start        = 1'b0;
        result_ready = 1'b1;
        tick();
        n_cmp++;
        if (result_valid !== 1'b0 || start_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_exit: got v=%b rdy=%b required 0/1", result_valid, start_ready);
        end
    endtask

    task automatic test_sweep_miss();
        bit ok; int hupd, ren, nchg; logic [7:0] seq; exp_t e; int tref;
        hash_word    = 32'hFFFF_FFFF;
        target       = 32'h0000_0000;
        result_ready = 1'b1;
        sb.push_back('{hit: 1'b0, nonce: 32'h7});
        sb.push_back('{hit: 1'b0, nonce: 32'h8});
        sb.push_back('{hit: 1'b1, nonce: 32'h9});
        do_start(32'h7, 1'b1);
        tref = t0;
        for (int k = 0; k < 3; k++) begin
            wait_valid(400, ok, hupd, ren, nchg, seq);
            n_cmp++;
            if (!ok || (cyc - tref) !== LAT) begin
                n_fail++; $display("FAIL sweep_latency_%0d: got %0d (ok=%b) required %0d", k, cyc - tref, ok, LAT);
            end
            e = sb_pop();
            n_cmp++;
            if ({result_hit, result_nonce} !== {e.hit, e.nonce}) begin
                n_fail++; $display("FAIL sweep_result_%0d: got hit=%b nonce=%h required hit=%b nonce=%h",
                                   k, result_hit, result_nonce, e.hit, e.nonce);
            end
            if (k == 1) target = 32'hFFFF_FFFF;   // force a hit on the third trial
            tick();
            tref = cyc;
            n_cmp++;
            if (busy !== (k < 2) || start_ready !== (k == 2)) begin
                n_fail++; $display("FAIL sweep_continue_%0d: got busy=%b rdy=%b required %b/%b",
                                   k, busy, start_ready, k < 2, k == 2);
            end
        end
    endtask

    task automatic test_wrap();
        bit ok; int hupd, ren, nchg; logic [7:0] seq; exp_t e;
        hash_word    = 32'hFFFF_FFFF;
        target       = 32'h0000_0000;
        result_ready = 1'b1;
        sb.push_back('{hit: 1'b0, nonce: 32'hFFFF_FFFF});
        do_start(32'hFFFF_FFFF, 1'b1);
        wait_valid(400, ok, hupd, ren, nchg, seq);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL wrap_timeout: result_valid never rose"); end
        e = sb_pop();
        n_cmp++;
        if ({result_hit, result_nonce} !== {e.hit, e.nonce}) begin
            n_fail++; $display("FAIL wrap_result: got hit=%b nonce=%h required hit=%b nonce=%h",
                               result_hit, result_nonce, e.hit, e.nonce);
        end
        tick();
        n_cmp++;
        if (start_ready !== 1'b1 || busy !== 1'b0 || nonce_cur !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL wrap_stop: got rdy=%b busy=%b nonce_cur=%h required 1/0/ffffffff",
                               start_ready, busy, nonce_cur);
        end
    endtask

    task automatic test_abort();
        bit ok; bit found; bit quiet; int hupd, ren, nchg; logic [7:0] seq; exp_t e;
        result_ready = 1'b1;
        hash_word    = 32'h0;
        target       = 32'h0;
        do_start(32'h1234, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (block_sel == 2'd1 && round_en && round_idx == 6'd30) found = 1'b1;
            else tick();
        end
        n_cmp++;
        if (!found) begin n_fail++; $display("FAIL abort_reach_r2: R2 round 30 never seen"); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || round_en !== 1'b0 || block_sel !== 2'd0 || round_idx !== 6'd0 ||
            result_valid !== 1'b0 || h_update !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle: got busy=%b ren=%b sel=%0d idx=%0d v=%b hu=%b required all 0",
                               busy, round_en, block_sel, round_idx, result_valid, h_update);
        end
        quiet = 1'b1;
        for (int i = 0; i < 250; i++) begin
            tick();
            if (result_valid || busy) quiet = 1'b0;
        end
        n_cmp++;
        if (!quiet) begin n_fail++; $display("FAIL abort_no_result: got activity after abort, required none"); end
        sb.push_back('{hit: 1'b1, nonce: 32'h55});
        do_start(32'h55, 1'b0);
        wait_valid(400, ok, hupd, ren, nchg, seq);
        n_cmp++;
        if (!ok || (cyc - t0) !== LAT) begin
            n_fail++; $display("FAIL abort_restart_latency: got %0d (ok=%b) required %0d", cyc - t0, ok, LAT);
        end
        e = sb_pop();
        n_cmp++;
        if ({result_hit, result_nonce} !== {e.hit, e.nonce}) begin
            n_fail++; $display("FAIL abort_restart_result: got hit=%b nonce=%h required hit=%b nonce=%h",
                               result_hit, result_nonce, e.hit, e.nonce);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit found;
        result_ready = 1'b1;
        do_start(32'hCAFE, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (block_sel == 2'd2 && round_en && round_idx == 6'd10) found = 1'b1;
            else tick();
        end
        n_cmp++;
        if (!found) begin n_fail++; $display("FAIL rstmid_reach_r3: R3 never seen"); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({block_sel, round_idx, round_en, h_update, nonce_cur, busy, result_valid,
             result_hit, result_nonce} !== '0 || start_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_async: got sel=%0d idx=%0d ren=%b busy=%b nc=%h v=%b rdy=%b required reset values",
                               block_sel, round_idx, round_en, busy, nonce_cur, result_valid, start_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (start_ready !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_release: got rdy=%b busy=%b v=%b required 1/0/0",
                               start_ready, busy, result_valid);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        nonce_in     = '0;
        sweep        = 1'b0;
        abort        = 1'b0;
        target       = '0;
        hash_word    = '0;
        result_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_sweep_miss();
        test_wrap();
        test_abort();
        test_reset_mid();
        n_cmp++;
        if (sb.size() !== 0) begin
            n_fail++; $display("FAIL sb_leftover: got %0d pending entries required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
